// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_HALT    = 2'd3
  } fetch_state_e;

  localparam logic [15:0] RESET_PC_DEF    = 16'h0000;
  localparam logic [3:0]  HALT_OPCODE_DEF = 4'hF;
  localparam logic [15:0] NOP_WORD        = 16'h0000;

  function automatic logic [15:0] pc_inc(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
interface fetch_if;
  logic        IMemReq;
  logic [15:0] IMemAddr;
  logic        IMemValid;
  logic [15:0] IMemInstr;

  modport master (output IMemReq, IMemAddr, input IMemValid, IMemInstr);
  modport slave  (input IMemReq, IMemAddr, output IMemValid, IMemInstr);
endinterface

// File: rtl/fetch_ifid_latch.sv
// IF/ID pipeline register: flush clears, stall holds, otherwise load or insert a bubble.
module ifid_latch
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        load_i,
  input  logic [15:0] instr_i,
  input  logic [15:0] pcplus2_i,
  output logic [15:0] instr_o,
  output logic [15:0] pcplus2_o,
  output logic        valid_o
);

  logic [15:0] instr_q, pcplus2_q;
  logic        valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q   <= NOP_WORD;
      pcplus2_q <= '0;
      valid_q   <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      if (load_i) begin
        instr_q   <= instr_i;
        pcplus2_q <= pcplus2_i;
        valid_q   <= 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign instr_o   = instr_q;
  assign pcplus2_o = pcplus2_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch.sv
// Fetch stage: PC, one-entry hold buffer and request FSM feeding the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating FetchCount/BubbleCount outputs.
//   state      | meaning
//   ST_FETCH   | request at PC outstanding
//   ST_HOLD    | fetched word buffered, decode stalled
//   ST_DISCARD | stale pre-redirect request outstanding, its response is dropped
//   ST_HALT    | HLT reached, waiting for a redirect
module fetch
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = RESET_PC_DEF,
  parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        BranchTaken,
  input  logic [15:0] BranchTarget,
  fetch_if.master     imem,
  output logic [15:0] instr,
  output logic [15:0] PCplus2,
  output logic        IFIDValid,
  output logic        Halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] FetchCount,
  output logic [15:0] BubbleCount
`endif
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d, req_addr_q, req_addr_d;
  logic [15:0]  buf_word_q, buf_word_d, buf_addr_q, buf_addr_d;
  logic         halted_q, halted_d;
  logic         ld, flush, req_out;
  logic [15:0]  ld_instr, ld_pc2;

  assign req_out       = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
  // Gated by rst so the bus is idle while reset is held.
  assign imem.IMemReq  = rst & req_out;
  assign imem.IMemAddr = req_addr_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_word_d = buf_word_q;
    buf_addr_d = buf_addr_q;
    halted_d   = halted_q;
    ld         = 1'b0;
    flush      = 1'b0;
    ld_instr   = imem.IMemInstr;
    ld_pc2     = pc_inc(pc_q);
    if (BranchTaken) begin
      flush      = 1'b1;
      pc_d       = BranchTarget & 16'hFFFE;
      halted_d   = 1'b0;
      buf_word_d = NOP_WORD;
      state_d    = (req_out && !imem.IMemValid) ? ST_DISCARD : ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem.IMemValid) begin
            if (stall) begin
              buf_word_d = imem.IMemInstr;
              buf_addr_d = pc_q;
              state_d    = ST_HOLD;
            end else begin
              ld = 1'b1;
              if (imem.IMemInstr[15:12] == HALT_OPCODE) state_d = ST_HALT;
              else pc_d = pc_inc(pc_q);
            end
          end
        end
        ST_HOLD: begin
          ld_instr = buf_word_q;
          ld_pc2   = pc_inc(buf_addr_q);
          if (!stall) begin
            ld = 1'b1;
            if (buf_word_q[15:12] == HALT_OPCODE) begin
              state_d = ST_HALT;
            end else begin
              pc_d    = pc_inc(pc_q);
              state_d = ST_FETCH;
            end
          end
        end
        ST_DISCARD: if (imem.IMemValid) state_d = ST_FETCH;
        ST_HALT:    halted_d = 1'b1;
        default:    state_d = ST_FETCH;
      endcase
    end
    // A discarded request must keep its address stable until its response arrives.
    req_addr_d = (state_d == ST_DISCARD) ? req_addr_q : pc_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      buf_word_q <= NOP_WORD;
      buf_addr_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      buf_word_q <= buf_word_d;
      buf_addr_q <= buf_addr_d;
      halted_q   <= halted_d;
    end
  end

  assign Halted = halted_q;

  ifid_latch u_ifid (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (flush),
    .stall_i  (stall),
    .load_i   (ld),
    .instr_i  (ld_instr),
    .pcplus2_i(ld_pc2),
    .instr_o  (instr),
    .pcplus2_o(PCplus2),
    .valid_o  (IFIDValid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (ld && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (!stall && !ld && (bubble_cnt_q != 16'hFFFF)) bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign FetchCount  = fetch_cnt_q;
  assign BubbleCount = bubble_cnt_q;
`endif

endmodule
